mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single memory/MMIO bus (RAM, XALU, LEDS behind the memory wrapper) between requester A (CPU datapath) and requester B (debug/program loader).
- Issues one single-cycle access per clock from the winning port.
- Supports a bounded bus lock for read-modify-write sequences.
- Routes synchronous read data back to the port that issued the read.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 8, address width
LOCK_MAX, 4, max consecutive granted cycles a port may hold the lock (1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
a_req  in  1  A requests an access this cycle
a_lock  in  1  A wants to keep the bus after this access
a_addr  in  ADDR_WIDTH  A address
a_din  in  DATA_WIDTH  A write data
a_we  in  1  A write (1) / read (0)
a_mmio  in  1  A targets MMIO space
a_gnt  out  1  A's access is on the bus this cycle
a_rvalid  out  1  A read data valid
a_rdata  out  DATA_WIDTH  A read data
b_req, b_lock, b_addr, b_din, b_we, b_mmio, b_gnt, b_rvalid, b_rdata: same as A, for B
mem_addr  out  ADDR_WIDTH  to memory wrapper addr
mem_din  out  DATA_WIDTH  to memory wrapper din
mem_we  out  1  to memory wrapper write_en
mem_mmio  out  1  to memory wrapper mmio
mem_dout  in  DATA_WIDTH  from memory wrapper dout; valid 1 cycle after read issue

Behaviour:
- Reset (async, rst=1): state IDLE, lock_cnt=0, last_gnt=B, a_rvalid=b_rvalid=0.
- gnt and mem_* are combinational from the current state and requests. An access occurs in the cycle x_gnt=1; the requester holds its request until granted.
- mem_* mux: follows the granted port. With no grant: mem_we=0, mem_addr=0, mem_din=0, mem_mmio=0.
- At most one gnt is high per cycle. x_gnt implies x_req.
- States:
  - IDLE: normal arbitration.
    - Single requester wins.
    - Both requesting: A wins (fixed priority; see Optional Feature).
    - If the winner has x_lock=1, go to LOCK_x with lock_cnt=1.
  - LOCK_A / LOCK_B: only the owner may be granted. The other port's gnt is 0 even if it requests.
    - Owner granted with lock=1 and lock_cnt<LOCK_MAX: stay, lock_cnt++.
    - Owner lock=0, or lock_cnt==LOCK_MAX: return to IDLE with lock_cnt=0.
    - On forced expiry (lock_cnt==LOCK_MAX): set a one-shot flag giving the other port priority in the next contended IDLE cycle.
    - Owner not requesting (req=0): no grant, but the lock is held until lock deasserts or LOCK_MAX idle-or-granted cycles elapse. lock_cnt increments every cycle while in LOCK_x.
- last_gnt updates on every grant.
- Read return:
  - x_rvalid is registered: x_rvalid <= x_gnt & ~x_we.
  - x_rdata = mem_dout while x_rvalid=1, else 0.
  - Back-to-back reads from alternating ports are allowed; each rvalid lands 1 cycle after its own grant.
- Writes have no response; a write is complete in its gnt cycle.
- Reset mid-lock: state returns to IDLE immediately, and pending rvalid is dropped.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN
- Defined: when both ports request in IDLE (and no expiry flag is set), the winner is the port opposite last_gnt.
- Undefined: fixed priority, A over B. The expiry flag still applies in both builds.

Test Plan:
- Reset, then a_req=1, a_we=1, a_addr=0x05, a_din=0x3C -> same cycle a_gnt=1, mem_we=1, mem_addr=0x05. Then an A read of 0x05 -> a_rvalid=1 one cycle later with a_rdata=0x3C.
- a_req and b_req both held 4 cycles, no lock:
  - fixed build: A granted all 4 cycles, b_gnt=0.
  - MEM_ARB_ROUND_ROBIN_EN build: grants alternate A, B, A, B.
- A read 0x10 (mmio=1, LEDS) then B read 0x20 on consecutive cycles -> a_rvalid in cycle 2 with LEDS value, b_rvalid in cycle 3 with RAM[0x20]. Never both rvalid in the same cycle.
- A takes lock with a_lock held high, b_req=1 throughout, LOCK_MAX=4 -> A granted 4 cycles, then B granted the next cycle even though a_req=1.
- A locks, then asserts rst=1 while in LOCK_A with b_req=1 -> all gnt and rvalid go 0 asynchronously. After release, B is granted the first cycle if a_req=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: request/lock/access fields towards the
// arbiter, grant and registered read-return back to the requester.
interface mem_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req;
   logic                  lock;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] din;
   logic                  we;
   logic                  mmio;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, lock, addr, din, we, mmio,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, lock, addr, din, we, mmio,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared memory/MMIO bus: grant and mem_* are same-cycle, read data
// returns 1 cycle after grant; a losing requester just holds req. MEM_ARB_ROUND_ROBIN_EN selects round-robin contention.
module mem_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int LOCK_MAX   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_arbiter_if.slave          a,
   mem_arbiter_if.slave          b,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_we,
   output logic                  mem_mmio,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

   state_t     state_q, state_d;
   logic [3:0] lock_cnt_q, lock_cnt_d;
   logic       prio_vld_q, prio_vld_d;
   logic       prio_b_q, prio_b_d;
   logic       a_rvalid_q, b_rvalid_q;
   logic       gnt_a, gnt_b;
   logic       contend_b;
   logic       rr_pick_b;
   logic       own_lock;
   logic       win_lock;
   logic [3:0] cnt_inc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_b_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_b_q <= 1'b1;
      end else if (gnt_a) begin
         last_b_q <= 1'b0;
      end else if (gnt_b) begin
         last_b_q <= 1'b1;
      end
   end

   assign rr_pick_b = ~last_b_q;
`else
   assign rr_pick_b = 1'b0;
`endif

   // A forced lock expiry overrides the normal contention rule exactly once.
   assign contend_b = prio_vld_q ? prio_b_q : rr_pick_b;
   assign own_lock  = (state_q == LOCK_A) ? a.lock : b.lock;
   assign win_lock  = (gnt_a & a.lock) | (gnt_b & b.lock);
   assign cnt_inc   = lock_cnt_q + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lock_cnt_q <= '0;
         prio_vld_q <= 1'b0;
         prio_b_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         prio_vld_q <= prio_vld_d;
         prio_b_q   <= prio_b_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      prio_vld_d = prio_vld_q;
      prio_b_d   = prio_b_q;
      case (state_q)
         LOCK_A, LOCK_B: begin
            // lock_cnt counts every held cycle, granted or not.
            if (!own_lock) begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end else if (cnt_inc >= LOCK_MAX_C) begin
               state_d    = IDLE;
               lock_cnt_d = '0;
               prio_vld_d = 1'b1;
               prio_b_d   = (state_q == LOCK_A);
            end else begin
               lock_cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
            if (a.req && b.req) begin
               prio_vld_d = 1'b0;
            end
            if (win_lock) begin
               if (LOCK_MAX_C == 4'd1) begin
                  prio_vld_d = 1'b1;
                  prio_b_d   = gnt_a;
               end else begin
                  state_d    = gnt_a ? LOCK_A : LOCK_B;
                  lock_cnt_d = 4'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      case (state_q)
         LOCK_A: gnt_a = a.req;
         LOCK_B: gnt_b = b.req;
         default: begin
            if (a.req && b.req) begin
               gnt_b = contend_b;
               gnt_a = ~contend_b;
            end else begin
               gnt_a = a.req;
               gnt_b = b.req;
            end
         end
      endcase
      // Reset must silence the bus immediately, not at the next edge.
      if (rst) begin
         gnt_a = 1'b0;
         gnt_b = 1'b0;
      end
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      mem_mmio = 1'b0;
      if (gnt_a) begin
         mem_we   = a.we;
         mem_addr = a.addr;
         mem_din  = a.din;
         mem_mmio = a.mmio;
      end else if (gnt_b) begin
         mem_we   = b.we;
         mem_addr = b.addr;
         mem_din  = b.din;
         mem_mmio = b.mmio;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         a_rvalid_q <= gnt_a & ~a.we;
         b_rvalid_q <= gnt_b & ~b.we;
      end
   end

   assign a.gnt    = gnt_a;
   assign b.gnt    = gnt_b;
   assign a.rvalid = a_rvalid_q;
   assign b.rvalid = b_rvalid_q;
   assign a.rdata  = a_rvalid_q ? mem_dout : '0;
   assign b.rdata  = b_rvalid_q ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model of grants, lock ownership and memory contents.
module tb_mem_arbiter;
   localparam int DW       = 8;
   localparam int AW       = 8;
   localparam int LOCK_MAX = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_we;
   logic          mem_mmio;
   logic [DW-1:0] mem_dout;

   mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
   mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst), .a(a_if), .b(b_if),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_mmio(mem_mmio), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // Memory wrapper stand-in: synchronous read, write on the access cycle.
   logic [DW-1:0] emu_ram [256];
   logic [DW-1:0] emu_mmio[256];
   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_mmio) emu_mmio[mem_addr] = mem_din;
         else          emu_ram[mem_addr]  = mem_din;
      end
      mem_dout <= mem_mmio ? emu_mmio[mem_addr] : emu_ram[mem_addr];
   end

   // Reference model: 0 = none, 1 = A, 2 = B
   logic [DW-1:0] ref_ram [256];
   logic [DW-1:0] ref_mmio[256];
   int m_owner, m_held, m_last, m_favour, last_win;
   logic e_a_rv, e_b_rv;
   logic [DW-1:0] e_a_rd, e_b_rd;
   logic obs_a_gnt, obs_b_gnt;
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_held = 0; m_last = 2; m_favour = 0; last_win = 0;
      e_a_rv = 1'b0; e_b_rv = 1'b0; e_a_rd = '0; e_b_rd = '0;
   endtask

   function automatic int pick();
      if (m_owner == 1) return a_if.req ? 1 : 0;
      if (m_owner == 2) return b_if.req ? 2 : 0;
      if (a_if.req && b_if.req) begin
         if (m_favour != 0) return m_favour;
         return RR ? 3 - m_last : 1;
      end
      if (a_if.req) return 1;
      if (b_if.req) return 2;
      return 0;
   endfunction

   task automatic tick();
      int win;
      logic lk, we, mm;
      logic [AW-1:0] ad;
      logic [DW-1:0] dd;
      @(negedge clk);
      if (rst) begin
         model_reset();
         win = 0;
      end else begin
         win = pick();
      end
      we = 1'b0; mm = 1'b0; ad = '0; dd = '0;
      if (win == 1) begin we = a_if.we; mm = a_if.mmio; ad = a_if.addr; dd = a_if.din; end
      if (win == 2) begin we = b_if.we; mm = b_if.mmio; ad = b_if.addr; dd = b_if.din; end
      chk("a_gnt", a_if.gnt, win == 1);
      chk("b_gnt", b_if.gnt, win == 2);
      chk("mem_we", mem_we, we);
      chk("mem_mmio", mem_mmio, mm);
      chk("mem_addr", mem_addr, ad);
      chk("mem_din", mem_din, dd);
      chk("a_rvalid", a_if.rvalid, e_a_rv);
      chk("b_rvalid", b_if.rvalid, e_b_rv);
      chk("a_rdata", a_if.rdata, e_a_rv ? e_a_rd : '0);
      chk("b_rdata", b_if.rdata, e_b_rv ? e_b_rd : '0);
      obs_a_gnt = a_if.gnt;
      obs_b_gnt = b_if.gnt;
      if (!rst) begin
         if (m_owner != 0) begin
            m_held++;
            lk = (m_owner == 1) ? a_if.lock : b_if.lock;
            if (!lk) begin
               m_owner = 0; m_held = 0;
            end else if (m_held >= LOCK_MAX) begin
               m_favour = 3 - m_owner; m_owner = 0; m_held = 0;
            end
         end else begin
            if (a_if.req && b_if.req) m_favour = 0;
            lk = (win == 1) ? a_if.lock : (win == 2) ? b_if.lock : 1'b0;
            if (lk) begin
               m_owner = win; m_held = 1;
               if (m_held >= LOCK_MAX) begin m_favour = 3 - win; m_owner = 0; m_held = 0; end
            end
         end
         if (win != 0) m_last = win;
         e_a_rv = (win == 1) && !we;
         e_b_rv = (win == 2) && !we;
         e_a_rd = mm ? ref_mmio[ad] : ref_ram[ad];
         e_b_rd = e_a_rd;
         if (win != 0 && we) begin
            if (mm) ref_mmio[ad] = dd;
            else    ref_ram[ad]  = dd;
         end
      end
      last_win = win;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic rq, input logic lk, input logic [AW-1:0] ad,
                          input logic [DW-1:0] dd, input logic we, input logic mm);
      a_if.req = rq; a_if.lock = lk; a_if.addr = ad; a_if.din = dd; a_if.we = we; a_if.mmio = mm;
   endtask

   task automatic drive_b(input logic rq, input logic lk, input logic [AW-1:0] ad,
                          input logic [DW-1:0] dd, input logic we, input logic mm);
      b_if.req = rq; b_if.lock = lk; b_if.addr = ad; b_if.din = dd; b_if.we = we; b_if.mmio = mm;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt_a;
      for (int i = 0; i < 256; i++) begin
         emu_ram[i]  = 8'(i * 37 + 11);
         ref_ram[i]  = 8'(i * 37 + 11);
         emu_mmio[i] = 8'(i ^ 8'hA5);
         ref_mmio[i] = 8'(i ^ 8'hA5);
      end
      rst = 1'b1;
      drive_a(0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0);
      model_reset();
      @(posedge clk); #1;
      tick();
      rst = 1'b0;
      tick();

      // Write then read back through port A
      drive_a(1, 0, 8'h05, 8'h3C, 1, 0);
      tick();
      chk("wr_gnt", obs_a_gnt, 1);
      drive_a(1, 0, 8'h05, 8'h00, 0, 0);
      tick();
      drive_a(0, 0, 0, 0, 0, 0);
      chk("rd_rvalid", a_if.rvalid, 1);
      chk("rd_data", a_if.rdata, 8'h3C);
      tick();

      // Contention without lock
      drive_a(1, 0, 8'h11, 8'h21, 1, 0);
      drive_b(1, 0, 8'h12, 8'h22, 1, 0);
      cnt_a = 0;
      repeat (4) begin
         tick();
         cnt_a += int'(obs_a_gnt);
      end
      chk("contend_a_count", cnt_a, RR ? 2 : 4);
      drive_a(0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0);
      tick();

      // Back-to-back reads from alternating ports
      drive_a(1, 0, 8'h10, 0, 0, 1);
      tick();
      drive_a(0, 0, 0, 0, 0, 0);
      chk("pipe_a_rvalid", a_if.rvalid, 1);
      chk("pipe_a_rdata", a_if.rdata, ref_mmio[8'h10]);
      drive_b(1, 0, 8'h20, 0, 0, 0);
      tick();
      drive_b(0, 0, 0, 0, 0, 0);
      chk("pipe_b_rvalid", b_if.rvalid, 1);
      chk("pipe_a_rvalid_off", a_if.rvalid, 0);
      chk("pipe_b_rdata", b_if.rdata, ref_ram[8'h20]);
      tick();

      // Lock held to expiry, then the other port gets the bus
      drive_a(1, 1, 8'h30, 8'h77, 1, 0);
      drive_b(1, 0, 8'h31, 8'h88, 1, 0);
      cnt_a = 0;
      repeat (4) begin
         tick();
         cnt_a += int'(obs_a_gnt);
      end
      chk("lock_a_count", cnt_a, 4);
      tick();
      chk("expiry_b_gnt", obs_b_gnt, 1);
      chk("expiry_a_gnt", obs_a_gnt, 0);
      drive_a(0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0);
      tick();

      // Reset while A holds the lock with a read in flight
      drive_a(1, 1, 8'h40, 0, 0, 0);
      drive_b(1, 0, 8'h41, 8'h05, 1, 0);
      tick();
      chk("pre_rst_rvalid", a_if.rvalid, 1);
      rst = 1'b1;
      #1;
      chk("rst_a_gnt", a_if.gnt, 0);
      chk("rst_b_gnt", b_if.gnt, 0);
      chk("rst_a_rvalid", a_if.rvalid, 0);
      chk("rst_b_rvalid", b_if.rvalid, 0);
      drive_a(0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_b_gnt", obs_b_gnt, 1);
      drive_b(0, 0, 0, 0, 0, 0);
      tick();

      // Random traffic; a losing requester keeps its request unchanged
      for (int c = 0; c < 400; c++) begin
         if (!a_if.req || last_win == 1)
            drive_a($urandom_range(0, 2) != 0, 0, 8'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
         if (!b_if.req || last_win == 2)
            drive_b($urandom_range(0, 2) != 0, 0, 8'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
         a_if.lock = $urandom_range(0, 3) != 0;
         b_if.lock = $urandom_range(0, 3) != 0;
         tick();
      end
      drive_a(0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0);
      repeat (LOCK_MAX + 1) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
